// File: rtl/esw_pkg.sv
// -----------------------------------------------------------------------------
// esw_pkg
// Shared definitions for the ESW packet-action dispatcher:
//   - flit header codes carried in flit bits [133:132]
//   - bit offsets inside the per-packet action word
//   - dispatcher FSM state encoding
//   - saturating 8-bit counter helper
// No ports (package).
// -----------------------------------------------------------------------------
package esw_pkg;

    localparam int FLIT_W = 134;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_MID  = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    localparam int ACT_DROP    = 0;
    localparam int ACT_IBM     = 1;
    localparam int ACT_MAP_LSB = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_e;

    // A single flit can raise two events of the same kind (e.g. an unexpected
    // head that also lacks its action), hence the 2-bit increment.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/esw_dispatch_port.sv
// -----------------------------------------------------------------------------
// esw_dispatch_port
// One registered output lane of the dispatcher (a GOE port or the IBM path).
// The strobes arriving here are already gated by this lane's mask bit.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   data_i        flit to forward
//   data_wr_i     write this flit on the lane
//   valid_i       packet keep flag for the end-of-packet strobe
//   valid_wr_i    end-of-packet strobe for the lane
//   data_o, data_wr_o, valid_o, valid_wr_o   registered lane outputs
// -----------------------------------------------------------------------------
module esw_dispatch_port
    import esw_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] data_i,
    input  logic              data_wr_i,
    input  logic              valid_i,
    input  logic              valid_wr_i,
    output logic [FLIT_W-1:0] data_o,
    output logic              data_wr_o,
    output logic              valid_o,
    output logic              valid_wr_o
);

    logic [FLIT_W-1:0] data_q;
    logic              data_wr_q;
    logic              valid_q;
    logic              valid_wr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            data_wr_q  <= 1'b0;
            valid_q    <= 1'b0;
            valid_wr_q <= 1'b0;
        end else begin
            data_wr_q  <= data_wr_i;
            valid_wr_q <= valid_wr_i;
            // valid is only meaningful alongside valid_wr; keep it low otherwise
            valid_q    <= valid_wr_i & valid_i;
            if (data_wr_i) begin
                data_q <= data_i;
            end
        end
    end

    assign data_o     = data_q;
    assign data_wr_o  = data_wr_q;
    assign valid_o    = valid_q;
    assign valid_wr_o = valid_wr_q;

endmodule

// File: rtl/esw_pkt_dispatch.sv
// -----------------------------------------------------------------------------
// esw_pkt_dispatch
// Replicates each packet of the 134-bit flit stream to any subset of NUM_PORTS
// GOE ports and/or the IBM path, as selected by the per-packet action word.
// The IBM copy is admitted only when bufm_ID_count > BUFM_THRESH at the head.
// All outputs are registered (1-cycle latency), no backpressure.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_data/in_data_wr               flit stream ([133:132] header code)
//   in_valid/in_valid_wr             keep flag / end-of-packet strobe (tail)
//   in_action/in_action_wr           {port bitmap, to_ibm, drop} / strobe (head)
//   in_tsn_md                        TSN metadata, sampled with in_action_wr
//   bufm_ID_count                    free IBM buffer IDs
//   out_ibm_*                        IBM path flits, strobes and metadata
//   out_port_*                       GOE port i at slice [134*i +: 134] / bit i
//   pktout_cnt, drop_cnt             forwarded / discarded packet counters (wrap)
//   bufm_drop_cnt, proto_err_cnt     credit refusals / framing errors (saturate)
// -----------------------------------------------------------------------------
module esw_pkt_dispatch
    import esw_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int BUFM_THRESH = 2,
    parameter int MD_W        = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [FLIT_W-1:0]           in_data,
    input  logic                        in_data_wr,
    input  logic                        in_valid,
    input  logic                        in_valid_wr,
    input  logic [NUM_PORTS+1:0]        in_action,
    input  logic                        in_action_wr,
    input  logic [MD_W-1:0]             in_tsn_md,
    input  logic [4:0]                  bufm_ID_count,
    output logic [FLIT_W-1:0]           out_ibm_data,
    output logic                        out_ibm_data_wr,
    output logic                        out_ibm_valid,
    output logic                        out_ibm_valid_wr,
    output logic [MD_W-1:0]             out_ibm_tsn_md,
    output logic                        out_ibm_tsn_md_wr,
    output logic [FLIT_W*NUM_PORTS-1:0] out_port_data,
    output logic [NUM_PORTS-1:0]        out_port_data_wr,
    output logic [NUM_PORTS-1:0]        out_port_valid,
    output logic [NUM_PORTS-1:0]        out_port_valid_wr,
    output logic [63:0]                 pktout_cnt,
    output logic [31:0]                 drop_cnt,
    output logic [7:0]                  bufm_drop_cnt,
    output logic [7:0]                  proto_err_cnt
);

    localparam int         NO     = NUM_PORTS + 1;   // lanes: GOE ports, then IBM
    localparam logic [4:0] THRESH = BUFM_THRESH[4:0];

    state_e          state_q, state_d;
    logic [NO-1:0]   mask_q, mask_d;
    logic [MD_W-1:0] md_q;
    logic            md_wr_q;
    logic [63:0]     pktout_q;
    logic [31:0]     drop_q;
    logic [7:0]      bufm_drop_q;
    logic [7:0]      proto_err_q;

    logic [NO-1:0]   data_en, end_en, end_val, new_mask;
    logic            md_wr, pkt_inc, bufm_inc;
    logic [1:0]      drop_n, err_n;
    logic            is_head, ibm_ok;

    assign is_head = (in_data[FLIT_W-1 -: 2] == HDR_HEAD);
    assign ibm_ok  = in_action[ACT_IBM] && (bufm_ID_count > THRESH);

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        data_en  = '0;
        end_en   = '0;
        end_val  = '0;
        new_mask = '0;
        md_wr    = 1'b0;
        pkt_inc  = 1'b0;
        bufm_inc = 1'b0;
        drop_n   = 2'd0;
        err_n    = 2'd0;

        if (in_data_wr && is_head) begin
            // A head while a packet is still open: terminate the open packet
            // as not-kept on its lanes in the same cycle the new head goes out.
            if (state_q != IDLE) begin
                end_en = mask_q;
                drop_n = drop_n + 2'd1;
                err_n  = err_n + 2'd1;
            end
            if (in_action_wr) begin
                if (!in_action[ACT_DROP]) begin
                    new_mask = {ibm_ok, in_action[ACT_MAP_LSB +: NUM_PORTS]};
                    bufm_inc = in_action[ACT_IBM] & ~ibm_ok;
                end
            end else begin
                err_n = err_n + 2'd1;
            end
            data_en = new_mask;
            md_wr   = new_mask[NUM_PORTS];
            if (in_valid_wr) begin
                // single-flit packet: head and tail in one cycle
                state_d = IDLE;
                mask_d  = '0;
                if (new_mask != '0) begin
                    end_en  = end_en | new_mask;
                    end_val = in_valid ? new_mask : '0;
                    if (in_valid) pkt_inc = 1'b1;
                    else          drop_n  = drop_n + 2'd1;
                end else begin
                    drop_n = drop_n + 2'd1;
                end
            end else begin
                state_d = (new_mask != '0) ? FWD : DROP;
                mask_d  = new_mask;
            end
        end else if (in_data_wr) begin
            case (state_q)
                FWD: begin
                    data_en = mask_q;
                    if (in_valid_wr) begin
                        end_en  = mask_q;
                        end_val = in_valid ? mask_q : '0;
                        if (in_valid) pkt_inc = 1'b1;
                        else          drop_n  = drop_n + 2'd1;
                        state_d = IDLE;
                        mask_d  = '0;
                    end
                end
                DROP: begin
                    if (in_valid_wr) begin
                        drop_n  = drop_n + 2'd1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    // body/tail flit with no open packet
                    err_n = err_n + 2'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            md_q        <= '0;
            md_wr_q     <= 1'b0;
            pktout_q    <= '0;
            drop_q      <= '0;
            bufm_drop_q <= '0;
            proto_err_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            md_wr_q     <= md_wr;
            if (md_wr) begin
                md_q <= in_tsn_md;
            end
            pktout_q    <= pktout_q + {63'd0, pkt_inc};
            drop_q      <= drop_q + {30'd0, drop_n};
            bufm_drop_q <= sat_add8(bufm_drop_q, {1'b0, bufm_inc});
            proto_err_q <= sat_add8(proto_err_q, err_n);
        end
    end

    logic [FLIT_W-1:0] lane_data [NO];
    logic [NO-1:0]     lane_dwr, lane_v, lane_vwr;

    for (genvar g = 0; g < NO; g++) begin : g_lane
        esw_dispatch_port u_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .data_i     (in_data),
            .data_wr_i  (data_en[g]),
            .valid_i    (end_val[g]),
            .valid_wr_i (end_en[g]),
            .data_o     (lane_data[g]),
            .data_wr_o  (lane_dwr[g]),
            .valid_o    (lane_v[g]),
            .valid_wr_o (lane_vwr[g])
        );
        if (g < NUM_PORTS) begin : g_goe
            assign out_port_data[FLIT_W*g +: FLIT_W] = lane_data[g];
        end
    end

    assign out_port_data_wr  = lane_dwr[NUM_PORTS-1:0];
    assign out_port_valid    = lane_v[NUM_PORTS-1:0];
    assign out_port_valid_wr = lane_vwr[NUM_PORTS-1:0];

    assign out_ibm_data      = lane_data[NUM_PORTS];
    assign out_ibm_data_wr   = lane_dwr[NUM_PORTS];
    assign out_ibm_valid     = lane_v[NUM_PORTS];
    assign out_ibm_valid_wr  = lane_vwr[NUM_PORTS];
    assign out_ibm_tsn_md    = md_q;
    assign out_ibm_tsn_md_wr = md_wr_q;

    assign pktout_cnt    = pktout_q;
    assign drop_cnt      = drop_q;
    assign bufm_drop_cnt = bufm_drop_q;
    assign proto_err_cnt = proto_err_q;

endmodule

// File: tb/tb_esw_pkt_dispatch.sv
// -----------------------------------------------------------------------------
// tb_esw_pkt_dispatch
// Directed stimulus for esw_pkt_dispatch (NUM_PORTS=4). Each driven flit pushes
// its expected per-lane response into a queue; a monitor pops and compares
// whenever a lane presents a strobe. Counters are compared directly.
// -----------------------------------------------------------------------------
module tb_esw_pkt_dispatch;
    import esw_pkg::*;

    localparam int NP = 4;
    localparam int NO = NP + 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [133:0]          in_data = '0;
    logic                  in_data_wr = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_valid_wr = 1'b0;
    logic [NP+1:0]         in_action = '0;
    logic                  in_action_wr = 1'b0;
    logic [23:0]           in_tsn_md = '0;
    logic [4:0]            bufm_ID_count = 5'd10;
    logic [133:0]          out_ibm_data;
    logic                  out_ibm_data_wr, out_ibm_valid, out_ibm_valid_wr;
    logic [23:0]           out_ibm_tsn_md;
    logic                  out_ibm_tsn_md_wr;
    logic [134*NP-1:0]     out_port_data;
    logic [NP-1:0]         out_port_data_wr, out_port_valid, out_port_valid_wr;
    logic [63:0]           pktout_cnt;
    logic [31:0]           drop_cnt;
    logic [7:0]            bufm_drop_cnt, proto_err_cnt;

    esw_pkt_dispatch #(.NUM_PORTS(NP), .BUFM_THRESH(2), .MD_W(24)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_data           (in_data),
        .in_data_wr        (in_data_wr),
        .in_valid          (in_valid),
        .in_valid_wr       (in_valid_wr),
        .in_action         (in_action),
        .in_action_wr      (in_action_wr),
        .in_tsn_md         (in_tsn_md),
        .bufm_ID_count     (bufm_ID_count),
        .out_ibm_data      (out_ibm_data),
        .out_ibm_data_wr   (out_ibm_data_wr),
        .out_ibm_valid     (out_ibm_valid),
        .out_ibm_valid_wr  (out_ibm_valid_wr),
        .out_ibm_tsn_md    (out_ibm_tsn_md),
        .out_ibm_tsn_md_wr (out_ibm_tsn_md_wr),
        .out_port_data     (out_port_data),
        .out_port_data_wr  (out_port_data_wr),
        .out_port_valid    (out_port_valid),
        .out_port_valid_wr (out_port_valid_wr),
        .pktout_cnt        (pktout_cnt),
        .drop_cnt          (drop_cnt),
        .bufm_drop_cnt     (bufm_drop_cnt),
        .proto_err_cnt     (proto_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         dwr;
        logic [133:0] data;
        logic         vwr;
        logic         v;
        logic         mdwr;
        logic [23:0]  md;
    } exp_t;

    exp_t expq [NO][$];
    int   checks   = 0;
    int   failures = 0;

    logic [NO-1:0] o_dwr, o_vwr, o_v;
    logic [133:0]  o_data [NO];

    always_comb begin
        o_dwr = {out_ibm_data_wr, out_port_data_wr};
        o_vwr = {out_ibm_valid_wr, out_port_valid_wr};
        o_v   = {out_ibm_valid, out_port_valid};
        for (int g = 0; g < NP; g++) o_data[g] = out_port_data[134*g +: 134];
        o_data[NP] = out_ibm_data;
    end

    // monitor: lane index NP is the IBM path
    initial begin
        exp_t e;
        logic mdo;
        logic ok;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int g = 0; g < NO; g++) begin
                    mdo = (g == NP) ? out_ibm_tsn_md_wr : 1'b0;
                    if (o_dwr[g] || o_vwr[g] || mdo) begin
                        checks++;
                        if (expq[g].size() == 0) begin
                            failures++;
                            $display("FAIL lane%0d unexpected output: dwr=%0b vwr=%0b v=%0b mdwr=%0b data=%h",
                                     g, o_dwr[g], o_vwr[g], o_v[g], mdo, o_data[g]);
                        end else begin
                            e  = expq[g].pop_front();
                            ok = (o_dwr[g] == e.dwr) && (!e.dwr || o_data[g] == e.data) &&
                                 (o_vwr[g] == e.vwr) && (!e.vwr || o_v[g] == e.v) &&
                                 (mdo == e.mdwr) && (!e.mdwr || out_ibm_tsn_md == e.md);
                            if (!ok) begin
                                failures++;
                                $display("FAIL lane%0d output: got dwr=%0b vwr=%0b v=%0b mdwr=%0b md=%h data=%h, want dwr=%0b vwr=%0b v=%0b mdwr=%0b md=%h data=%h",
                                         g, o_dwr[g], o_vwr[g], o_v[g], mdo, out_ibm_tsn_md, o_data[g],
                                         e.dwr, e.vwr, e.v, e.mdwr, e.md, e.data);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Drive one flit for one cycle and queue the expected lane responses.
    task automatic drive(input logic [1:0] hdr, input logic [7:0] id, input logic [7:0] idx,
                         input logic awr, input logic [NP+1:0] act, input logic [23:0] md,
                         input logic vwr, input logic v,
                         input logic [NO-1:0] dmask, input logic [NO-1:0] emask,
                         input logic [NO-1:0] evmask, input logic exp_mdwr);
        exp_t e;
        logic [133:0] f;
        f = {hdr, 116'd0, id, idx};
        in_data = f; in_data_wr = 1'b1;
        in_action_wr = awr; in_action = act; in_tsn_md = md;
        in_valid_wr = vwr; in_valid = v;
        for (int g = 0; g < NO; g++) begin
            if (dmask[g] || emask[g] || (g == NP && exp_mdwr)) begin
                e.dwr  = dmask[g];
                e.data = f;
                e.vwr  = emask[g];
                e.v    = evmask[g];
                e.mdwr = (g == NP) ? exp_mdwr : 1'b0;
                e.md   = md;
                expq[g].push_back(e);
            end
        end
        @(posedge clk); #1;
        in_data_wr = 1'b0; in_action_wr = 1'b0; in_valid_wr = 1'b0; in_valid = 1'b0;
    endtask

    // n-flit packet (n >= 2) expected on lanes `mask` (bit NP = IBM).
    task automatic send_pkt(input logic [7:0] id, input int n, input logic [NP+1:0] act,
                            input logic [23:0] md, input logic v, input logic [NO-1:0] mask);
        drive(HDR_HEAD, id, 8'd0, 1'b1, act, md, 1'b0, 1'b0, mask, '0, '0, mask[NP]);
        for (int i = 1; i < n - 1; i++)
            drive(HDR_MID, id, 8'(i), 1'b0, '0, '0, 1'b0, 1'b0, mask, '0, '0, 1'b0);
        drive(HDR_TAIL, id, 8'(n - 1), 1'b0, '0, '0, 1'b1, v, mask, mask, v ? mask : '0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        idle(3);
        chk("reset pktout_cnt", pktout_cnt, 64'd0);
        chk("reset drop_cnt", {32'd0, drop_cnt}, 64'd0);
        chk("reset bufm_drop_cnt", {56'd0, bufm_drop_cnt}, 64'd0);
        chk("reset proto_err_cnt", {56'd0, proto_err_cnt}, 64'd0);
        chk("reset strobes", {52'd0, out_port_data_wr, out_port_valid_wr, out_ibm_data_wr,
                              out_ibm_valid_wr, out_ibm_tsn_md_wr}, 64'd0);
        #4 rst_n = 1'b1;
        idle(2);

        // multicast to ports 0 and 2
        send_pkt(8'h01, 5, {4'b0101, 1'b0, 1'b0}, 24'h0, 1'b1, 5'b00101);
        idle(2);
        chk("t1 pktout_cnt", pktout_cnt, 64'd1);

        // IBM only, enough credit, metadata on head
        bufm_ID_count = 5'd5;
        send_pkt(8'h02, 4, {4'b0000, 1'b1, 1'b0}, 24'hABCDEF, 1'b1, 5'b10000);
        idle(2);
        chk("t2 pktout_cnt", pktout_cnt, 64'd2);
        chk("t2 bufm_drop_cnt", {56'd0, bufm_drop_cnt}, 64'd0);

        // IBM refused at credit == threshold, port 3 still forwards
        bufm_ID_count = 5'd2;
        send_pkt(8'h03, 3, {4'b1000, 1'b1, 1'b0}, 24'h123456, 1'b1, 5'b01000);
        idle(2);
        bufm_ID_count = 5'd10;
        chk("t3 bufm_drop_cnt", {56'd0, bufm_drop_cnt}, 64'd1);
        chk("t3 pktout_cnt", pktout_cnt, 64'd3);

        // drop action overrides the bitmap, then normal packet
        send_pkt(8'h04, 3, {4'b1111, 1'b0, 1'b1}, 24'h0, 1'b1, 5'b00000);
        idle(2);
        chk("t4 drop_cnt", {32'd0, drop_cnt}, 64'd1);
        chk("t4 pktout_cnt after drop", pktout_cnt, 64'd3);
        send_pkt(8'h05, 3, {4'b0001, 1'b0, 1'b0}, 24'h0, 1'b1, 5'b00001);
        idle(2);
        chk("t4 pktout_cnt", pktout_cnt, 64'd4);

        // head, 2 middles, new head: open packet on port 1 closed with valid=0
        drive(HDR_HEAD, 8'h06, 8'd0, 1'b1, {4'b0010, 1'b0, 1'b0}, 24'h0, 1'b0, 1'b0, 5'b00010, '0, '0, 1'b0);
        drive(HDR_MID,  8'h06, 8'd1, 1'b0, '0, 24'h0, 1'b0, 1'b0, 5'b00010, '0, '0, 1'b0);
        drive(HDR_MID,  8'h06, 8'd2, 1'b0, '0, 24'h0, 1'b0, 1'b0, 5'b00010, '0, '0, 1'b0);
        drive(HDR_HEAD, 8'h07, 8'd0, 1'b1, {4'b0100, 1'b0, 1'b0}, 24'h0, 1'b0, 1'b0, 5'b00100, 5'b00010, 5'b00000, 1'b0);
        drive(HDR_MID,  8'h07, 8'd1, 1'b0, '0, 24'h0, 1'b0, 1'b0, 5'b00100, '0, '0, 1'b0);
        drive(HDR_TAIL, 8'h07, 8'd2, 1'b0, '0, 24'h0, 1'b1, 1'b1, 5'b00100, 5'b00100, 5'b00100, 1'b0);
        idle(2);
        chk("t5 proto_err_cnt", {56'd0, proto_err_cnt}, 64'd1);
        chk("t5 drop_cnt", {32'd0, drop_cnt}, 64'd2);
        chk("t5 pktout_cnt", pktout_cnt, 64'd5);

        // tail with valid=0: forwarded as not-kept, counted as dropped
        send_pkt(8'h08, 2, {4'b0001, 1'b0, 1'b0}, 24'h0, 1'b0, 5'b00001);
        idle(2);
        chk("t6 drop_cnt", {32'd0, drop_cnt}, 64'd3);
        chk("t6 pktout_cnt", pktout_cnt, 64'd5);

        // reset after the 3rd flit of a 6-flit packet
        drive(HDR_HEAD, 8'h09, 8'd0, 1'b1, {4'b0011, 1'b0, 1'b0}, 24'h0, 1'b0, 1'b0, 5'b00011, '0, '0, 1'b0);
        drive(HDR_MID,  8'h09, 8'd1, 1'b0, '0, 24'h0, 1'b0, 1'b0, 5'b00011, '0, '0, 1'b0);
        drive(HDR_MID,  8'h09, 8'd2, 1'b0, '0, 24'h0, 1'b0, 1'b0, 5'b00011, '0, '0, 1'b0);
        #6 rst_n = 1'b0;
        #2;
        chk("rst port data", {63'd0, |out_port_data}, 64'd0);
        chk("rst strobes", {52'd0, out_port_data_wr, out_port_valid_wr, out_ibm_data_wr,
                            out_ibm_valid_wr, out_ibm_tsn_md_wr}, 64'd0);
        chk("rst pktout_cnt", pktout_cnt, 64'd0);
        #8 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(HDR_MID,  8'h09, 8'd3, 1'b0, '0, 24'h0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(HDR_MID,  8'h09, 8'd4, 1'b0, '0, 24'h0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(HDR_TAIL, 8'h09, 8'd5, 1'b0, '0, 24'h0, 1'b1, 1'b1, '0, '0, '0, 1'b0);
        idle(2);
        chk("t7 proto_err_cnt", {56'd0, proto_err_cnt}, 64'd3);
        chk("t7 drop_cnt", {32'd0, drop_cnt}, 64'd0);
        send_pkt(8'h0A, 4, {4'b1001, 1'b0, 1'b0}, 24'h0, 1'b1, 5'b01001);
        idle(3);
        chk("t7 pktout_cnt", pktout_cnt, 64'd1);

        for (int g = 0; g < NO; g++) begin
            chk($sformatf("lane%0d pending expected outputs", g), 64'(expq[g].size()), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/esw_pkt_dispatch.md
Name: esw_pkt_dispatch

Overview:
- Parametrised packet-action dispatcher for the ESW pipeline. Successor to the fixed two-GOE-port action stage.
- Takes the 134-bit flit stream plus per-packet action from the forwarding stage.
- Replicates each packet to any subset of NUM_PORTS GOE ports and/or the IBM path (with TSN metadata).
- New versus the fixed stage: multicast bitmap, bufm-credit admission on the IBM path, and drop/error counters.

Parameters:
- NUM_PORTS, 4, number of GOE output ports (1..8)
- BUFM_THRESH, 2, IBM copy is admitted only if bufm_ID_count > BUFM_THRESH at head
- MD_W, 24, TSN metadata width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  134  flit; [133:132] 01=head, 11=middle, 10=tail
- in_data_wr  in  1  flit strobe
- in_valid  in  1  packet keep flag, sampled with in_valid_wr
- in_valid_wr  in  1  end-of-packet strobe, coincident with the tail flit
- in_action  in  NUM_PORTS+2  [NUM_PORTS+1:2] port bitmap, [1] to_ibm, [0] drop
- in_action_wr  in  1  action strobe, coincident with the head flit
- in_tsn_md  in  MD_W  metadata, sampled with in_action_wr
- bufm_ID_count  in  5  free buffer IDs in IBM
- out_ibm_data / out_ibm_data_wr / out_ibm_valid / out_ibm_valid_wr  out  134/1/1/1  IBM path
- out_ibm_tsn_md  out  MD_W  metadata, on IBM head cycle
- out_ibm_tsn_md_wr  out  1  metadata strobe, on IBM head cycle
- out_port_data  out  134*NUM_PORTS  port i at slice [134*i+:134]
- out_port_data_wr, out_port_valid, out_port_valid_wr  out  NUM_PORTS each  per-port strobes and flags
- pktout_cnt  out  64  packets forwarded with valid=1 on at least one output
- drop_cnt  out  32  packets fully discarded
- bufm_drop_cnt  out  8  IBM copies refused for credit; saturates at 255
- proto_err_cnt  out  8  framing errors; saturates at 255

Behaviour:
- Reset: all outputs, counters and state are 0; FSM goes to IDLE.
- Latency: every output is registered, 1 cycle from input. There is no backpressure; one flit is accepted per cycle.
- FSM states and transitions:
  - IDLE, head flit with in_action_wr=1: latch mask = bitmap plus (to_ibm AND bufm_ID_count>BUFM_THRESH), unless drop=1 or the resulting mask is 0. Latch in_tsn_md.
  - IDLE, mask nonzero: go to FWD.
  - IDLE, mask zero: go to DROP.
  - FWD: each flit is written to every output whose mask bit is set; out_*_data_wr=1 for exactly those outputs, 0 for the rest.
  - IBM in the mask: out_ibm_tsn_md_wr pulses on the head-flit output cycle only.
  - Tail (in_valid_wr): out_*_valid_wr pulses on the masked outputs with out_*_valid = in_valid; return to IDLE.
  - Tail with in_valid=1: pktout_cnt += 1.
  - Tail with in_valid=0: drop_cnt += 1.
  - DROP: flits are consumed and nothing is output. Tail: drop_cnt += 1; return to IDLE.
- bufm_drop_cnt increments whenever to_ibm=1 and drop=0 but credit is insufficient, even if GOE ports still forward.
- Framing error handling (each case proto_err_cnt += 1):
  - Head without in_action_wr: treat as action drop (DROP state).
  - Non-head flit in IDLE: discarded.
  - Head flit while in FWD/DROP: close the open packet on the masked outputs with valid_wr=1, valid=0 in the same output cycle as the new head; drop_cnt += 1; the new head is processed per the IDLE rules, so the next output cycle carries the new head.
- in_action_wr outside a head flit is ignored.
- Counters wrap (pktout_cnt, drop_cnt) or saturate (bufm_drop_cnt, proto_err_cnt) as listed; simultaneous increments of different counters are independent.
- Asynchronous reset mid-packet: the FSM returns to IDLE immediately. Remaining flits of that packet arrive in IDLE as non-head flits and are discarded under the framing rules. No partial valid_wr is generated.

Decomposition:
- Shared package esw_pkg:
  - Header codes HDR_HEAD=2'b01, HDR_MID=2'b11, HDR_TAIL=2'b10.
  - Action field offsets ACT_DROP=0, ACT_IBM=1, ACT_MAP_LSB=2.
  - FSM state enum {IDLE, FWD, DROP}.
- One natural sub-module, esw_dispatch_port: a registered output stage (data, data_wr, valid, valid_wr gated by one mask bit).
  - Instantiated NUM_PORTS+1 times by generate: NUM_PORTS GOE ports plus the IBM port.

Test Plan:
- NUM_PORTS=4, 5-flit packet, action bitmap=4'b0101, to_ibm=0, in_valid=1 -> ports 0 and 2 emit 5 flits 1 cycle later with valid_wr on the tail, valid=1; ports 1/3 and IBM silent; pktout_cnt=1.
- to_ibm=1, bitmap=0, bufm_ID_count=5, md=24'hABCDEF -> IBM emits the packet; tsn_md=ABCDEF with md_wr on the head cycle only.
- to_ibm=1, bitmap=4'b1000, bufm_ID_count=2 -> port 3 forwards; IBM silent; bufm_drop_cnt=1; pktout_cnt=1.
- drop=1, bitmap=4'b1111 -> no outputs; drop_cnt=1. Next packet with bitmap=0001 forwarded normally.
- Head, 2 middle flits, then a new head (no tail) -> first packet closed with valid=0 on its ports; proto_err_cnt=1, drop_cnt=1; second packet forwarded intact.
- rst_n low for 1 cycle after the 3rd flit of a 6-flit packet -> all outputs 0; the 3 remaining flits are discarded with proto_err_cnt=3; the next packet is forwarded correctly.
